// File: rtl/emaxi_pkg.sv
// rtl/emaxi_pkg.sv - shared AXI burst/response encodings and read-responder state type
package emaxi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/emaxi_burst_addr_gen.sv
// rtl/emaxi_burst_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module emaxi_burst_addr_gen
    import emaxi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] span_mask;

    // Wrap span is (len+1) beats of (1<<size) bytes; legal wrap lengths keep it a power of two.
    always_comb begin
        bytes     = ONE << size;
        incr_addr = addr + bytes;
        span_mask = (({{(ADDR_W-8){1'b0}}, len} + ONE) << size) - ONE;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~span_mask) | (incr_addr & span_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/emaxi_slave_read_responder.sv
// rtl/emaxi_slave_read_responder.sv - AXI4 read slave serving bursts from a 1-cycle-latency memory port
module emaxi_slave_read_responder
    import emaxi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 12
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,

    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,

    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int SIZE_MAX = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_q;
    logic              err_q;

    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] size_mask;
    logic              wrap_len_ok;
    logic              ar_err;

    assign s_axi_arready = (state == IDLE) & ~rst;

    // Classify the incoming request; an erroneous burst is answered without touching memory.
    always_comb begin
        size_mask   = (ONE << s_axi_arsize) - ONE;
        wrap_len_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                      (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
        ar_err      = 1'b0;
        if (s_axi_arburst == BURST_RSVD) begin
            ar_err = 1'b1;
        end
        if (s_axi_arsize > 3'(SIZE_MAX)) begin
            ar_err = 1'b1;
        end
        if ((s_axi_arburst == BURST_WRAP) &&
            (!wrap_len_ok || ((s_axi_araddr & size_mask) != '0))) begin
            ar_err = 1'b1;
        end
    end

    emaxi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Burst sequencer: one memory read per OKAY beat, back-to-back SLVERR beats otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= BURST_FIXED;
            beat_q       <= '0;
            err_q        <= 1'b0;
            s_axi_rid    <= '0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rlast  <= 1'b0;
            s_axi_rvalid <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_arvalid) begin
                        addr_q    <= s_axi_araddr;
                        len_q     <= s_axi_arlen;
                        size_q    <= s_axi_arsize;
                        burst_q   <= s_axi_arburst;
                        beat_q    <= '0;
                        err_q     <= ar_err;
                        s_axi_rid <= s_axi_arid;
                        if (ar_err) begin
                            s_axi_rvalid <= 1'b1;
                            s_axi_rresp  <= RESP_SLVERR;
                            s_axi_rdata  <= '0;
                            s_axi_rlast  <= (s_axi_arlen == 8'd0);
                            state        <= RESP;
                        end else begin
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= s_axi_araddr;
                            state       <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    mem_rd_en <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    s_axi_rdata  <= mem_rd_data;
                    s_axi_rvalid <= 1'b1;
                    s_axi_rresp  <= RESP_OKAY;
                    s_axi_rlast  <= (beat_q == len_q);
                    state        <= RESP;
                end
                RESP: begin
                    if (s_axi_rready) begin
                        if (beat_q == len_q) begin
                            s_axi_rvalid <= 1'b0;
                            s_axi_rlast  <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= next_addr;
                            if (err_q) begin
                                s_axi_rlast <= ((beat_q + 8'd1) == len_q);
                            end else begin
                                s_axi_rvalid <= 1'b0;
                                s_axi_rlast  <= 1'b0;
                                mem_rd_en    <= 1'b1;
                                mem_rd_addr  <= next_addr;
                                state        <= FETCH;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
